// File: rtl/max_pool_unit.sv
// Purpose : streaming signed max-pooling over non-overlapping k x k windows (raster input).
// Latency : one cycle from the window's final accepted sample to valid_op/data_out.
// Backpres: none; data_valid gaps stall every counter and hold partial maxima.
//
// Ports: clk, rst_n (sync, active-low); enable/size_act/size_kernel/number_feature
// start a job from IDLE; data_in/data_valid carry samples; data_out/valid_op carry one
// result per window; busy is high in RUN/DRAIN; done pulses once per job.
// Optional macro POOL_RELU_EN clamps negative results to zero before registering.
module max_pool_unit #(
  parameter int DATA_W  = 16,
  parameter int MAX_ACT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [7:0]        size_act,
  input  logic [7:0]        size_kernel,
  input  logic [7:0]        number_feature,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_op,
  output logic              busy,
  output logic              done
);

  localparam int LB_D  = (MAX_ACT / 2 > 0) ? MAX_ACT / 2 : 1;
  localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t r_state, w_state_nxt;

  // Job configuration latched on start
  logic [7:0] r_size_act, r_k, r_nfeat, r_nwin;

  // Position counters
  logic [7:0] r_col, r_row, r_feat, r_kc, r_kr, r_wx, r_wy;

  logic signed [DATA_W-1:0] r_hmax;
  logic signed [DATA_W-1:0] r_lbuf [LB_D];
  logic        [DATA_W-1:0] r_data_out;
  logic                     r_valid_op;
  logic                     r_done_late;

  logic                     w_start, w_degen, w_acc;
  logic                     w_last_col, w_last_row, w_last_feat, w_last_smp;
  logic                     w_kc_end, w_kr_end, w_win_act;
  logic [7:0]               w_nwin;
  logic [LB_AW-1:0]         w_lb_idx;
  logic signed [DATA_W-1:0] w_din, w_h, w_lb_rd, w_lb_max, w_res;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign w_din   = $signed(data_in);
  assign w_start = (r_state == S_IDLE) && enable;
  assign w_degen = (size_kernel == 8'd0) || (number_feature == 8'd0) || (size_act == 8'd0);
  // Window count per axis; floor division drops remainder rows/columns
  assign w_nwin  = (size_kernel == 8'd0) ? 8'd0 : size_act / size_kernel;
  assign w_acc   = (r_state == S_RUN) && data_valid;

  assign w_last_col  = (r_col  == r_size_act - 8'd1);
  assign w_last_row  = (r_row  == r_size_act - 8'd1);
  assign w_last_feat = (r_feat == r_nfeat    - 8'd1);
  assign w_last_smp  = w_last_col && w_last_row && w_last_feat;

  assign w_kc_end  = (r_kc == r_k - 8'd1);
  assign w_kr_end  = (r_kr == r_k - 8'd1);
  assign w_win_act = (r_wx < r_nwin) && (r_wy < r_nwin);

  // With k>=2 an active window index is below size_act/2, so it always fits the buffer;
  // with k=1 the buffer is never written and its read value is never selected.
  assign w_lb_idx = r_wx[LB_AW-1:0];
  assign w_lb_rd  = r_lbuf[w_lb_idx];

  assign w_h      = (r_kc == 8'd0) ? w_din : smax(r_hmax, w_din);
  assign w_lb_max = smax(w_lb_rd, w_h);
  // kr=0 on the last window row only happens for k=1: pure passthrough
  assign w_res    = (r_kr == 8'd0) ? w_h : w_lb_max;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = w_degen ? S_DRAIN : S_RUN;
      S_RUN:   if (w_acc && w_last_smp) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // When the final sample closes a window, done is deferred one cycle so it lands
  // after that last valid_op; otherwise it fires during DRAIN itself.
  always_comb begin
    busy = (r_state == S_RUN) || (r_state == S_DRAIN);
    done = ((r_state == S_DRAIN) && !r_valid_op) || r_done_late;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_done_late <= 1'b0;
    else        r_done_late <= (r_state == S_DRAIN) && r_valid_op;
  end

  // ---------------- Counters, horizontal max, result register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_size_act <= '0;
      r_k        <= '0;
      r_nfeat    <= '0;
      r_nwin     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_feat     <= '0;
      r_kc       <= '0;
      r_kr       <= '0;
      r_wx       <= '0;
      r_wy       <= '0;
      r_hmax     <= '0;
      r_data_out <= '0;
      r_valid_op <= 1'b0;
    end else begin
      r_valid_op <= 1'b0;
      if (w_start) begin
        r_size_act <= size_act;
        r_k        <= size_kernel;
        r_nfeat    <= number_feature;
        r_nwin     <= w_nwin;
        r_col      <= '0;
        r_row      <= '0;
        r_feat     <= '0;
        r_kc       <= '0;
        r_kr       <= '0;
        r_wx       <= '0;
        r_wy       <= '0;
      end else if (w_acc) begin
        r_hmax <= w_h;

        if (w_kc_end && w_win_act && w_kr_end) begin
`ifdef POOL_RELU_EN
          r_data_out <= w_res[DATA_W-1] ? '0 : w_res;
`else
          r_data_out <= w_res;
`endif
          r_valid_op <= 1'b1;
        end

        if (w_last_col) begin
          // Row end: restart column-side counters regardless of any remainder columns
          r_col <= '0;
          r_kc  <= '0;
          r_wx  <= '0;
          if (w_last_row) begin
            r_row  <= '0;
            r_kr   <= '0;
            r_wy   <= '0;
            r_feat <= w_last_feat ? 8'd0 : r_feat + 8'd1;
          end else begin
            r_row <= r_row + 8'd1;
            r_kr  <= w_kr_end ? 8'd0 : r_kr + 8'd1;
            if (w_kr_end) r_wy <= r_wy + 8'd1;
          end
        end else begin
          r_col <= r_col + 8'd1;
          r_kc  <= w_kc_end ? 8'd0 : r_kc + 8'd1;
          if (w_kc_end) r_wx <= r_wx + 8'd1;
        end
      end
    end
  end

  // ---------------- Vertical line buffer ----------------
  // Not cleared between windows or features: the first window row always overwrites.
  always_ff @(posedge clk) begin
    if (w_acc && w_kc_end && w_win_act && !w_kr_end) begin
      r_lbuf[w_lb_idx] <= (r_kr == 8'd0) ? w_h : w_lb_max;
    end
  end

  assign data_out = r_data_out;
  assign valid_op = r_valid_op;

endmodule

// File: tb/tb_max_pool_unit.sv
// Purpose : self-checking bench for max_pool_unit using a result scoreboard.
// Latency : expected window maxima are queued at stimulus time, popped on valid_op.
// Backpres: data_valid gaps are inserted randomly on some frames.
module tb_max_pool_unit;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [7:0]    size_act, size_kernel, number_feature;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic [DW-1:0] data_out;
  logic          valid_op, busy, done;

  max_pool_unit #(.DATA_W(DW), .MAX_ACT(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .size_act       (size_act),
    .size_kernel    (size_kernel),
    .number_feature (number_feature),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .data_out       (data_out),
    .valid_op       (valid_op),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int  n_vec = 0;
  int  n_err = 0;
  int  exp_q[$];
  int  done_cnt = 0;
  time t_done = 0;
  time t_acc = 0;
  int  vals[];

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (valid_op) begin
      if (exp_q.size() > 0) begin
        int e;
        e = exp_q.pop_front();
        check("data_out", $signed(data_out), e);
      end else begin
        check("unexpected_valid_op", int'(valid_op), 0);
      end
    end
    if (done) begin
      done_cnt++;
      t_done = $time;
    end
  end

  // Reference: whole-frame pooling over the stored samples
  task automatic model(input int sa, input int k, input int nf);
    int n, m, v;
    n = sa / k;
    for (int f = 0; f < nf; f++)
      for (int wy = 0; wy < n; wy++)
        for (int wx = 0; wx < n; wx++) begin
          m = vals[f*sa*sa + wy*k*sa + wx*k];
          for (int dy = 0; dy < k; dy++)
            for (int dx = 0; dx < k; dx++) begin
              v = vals[f*sa*sa + (wy*k+dy)*sa + wx*k + dx];
              if (v > m) m = v;
            end
`ifdef POOL_RELU_EN
          if (m < 0) m = 0;
`endif
          exp_q.push_back(m);
        end
  endtask

  // mode 0: ramp + 100*feature, 1: negated ramp, 2: random signed
  task automatic build(input int sa, input int nf, input int mode);
    vals = new[sa*sa*nf];
    for (int f = 0; f < nf; f++)
      for (int i = 0; i < sa*sa; i++) begin
        case (mode)
          0:       vals[f*sa*sa+i] = i + 100*f;
          1:       vals[f*sa*sa+i] = -i;
          default: vals[f*sa*sa+i] = int'($urandom_range(0, 65535)) - 32768;
        endcase
      end
  endtask

  task automatic start(input int sa, input int k, input int nf);
    size_act       = 8'(sa);
    size_kernel    = 8'(k);
    number_feature = 8'(nf);
    enable         = 1'b1;
    @(posedge clk);
    t_acc = $time;
    #1;
    enable = 1'b0;
  endtask

  task automatic drive(input int idx, input int gap);
    repeat ($urandom_range(0, gap)) begin
      data_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    data_valid = 1'b1;
    data_in    = DW'(vals[idx]);
    @(posedge clk);
    t_acc = $time;
    #1;
  endtask

  task automatic run_frame(input int sa, input int k, input int nf, input int mode,
                           input int gap);
    build(sa, nf, mode);
    model(sa, k, nf);
    done_cnt = 0;
    start(sa, k, nf);
    check("busy_run", int'(busy), 1);
    for (int i = 0; i < sa*sa*nf; i++) drive(i, gap);
    data_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("done_count", done_cnt, 1);
    // done lands one cycle after the final valid_op, or one cycle after the
    // final sample when that sample sits in an ignored remainder row
    check("done_latency", int'(t_done - t_acc), (sa % k == 0) ? 15 : 5);
    check("scoreboard_empty", exp_q.size(), 0);
    check("busy_idle", int'(busy), 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    enable         = 1'b0;
    data_valid     = 1'b0;
    data_in        = '0;
    size_act       = '0;
    size_kernel    = '0;
    number_feature = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", int'(data_out), 0);
    check("rst_valid_op", int'(valid_op), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame(4, 2, 1, 0, 0);   // 5 7 13 15
    run_frame(4, 2, 1, 1, 0);   // 0 -2 -8 -10, or all 0 with ReLU
    run_frame(5, 2, 1, 0, 0);   // 6 8 16 18, remainder dropped
    run_frame(4, 2, 2, 0, 3);   // two features with gaps
    run_frame(6, 3, 1, 0, 0);   // 14 17 32 35
    run_frame(4, 1, 1, 0, 0);   // passthrough
    run_frame(8, 2, 2, 2, 2);   // random signed data
    run_frame(7, 3, 1, 2, 1);   // random, remainder rows and columns

    // Zero kernel: straight through DRAIN, done pulses, no results
    done_cnt = 0;
    start(4, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("degen_done_count", done_cnt, 1);
    check("degen_done_latency", int'(t_done - t_acc), 5);
    check("degen_busy", int'(busy), 0);

    // Reset mid-frame after 6 samples; the window closed by sample 5 is emitted first
    build(4, 1, 0);
    start(4, 2, 1);
    exp_q.push_back(5);
    for (int i = 0; i < 6; i++) drive(i, 0);
    rst_n      = 1'b0;
    data_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_valid_op", int'(valid_op), 0);
    check("midrst_data_out", int'(data_out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_q_empty", exp_q.size(), 0);
    run_frame(4, 2, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
